// File: rtl/tcm_mem_pkg.sv
// tcm_mem_pkg
// Shared types and constants for the latency-configurable simulation TCM
// (tcm_mem_lat) and its response delay line (tcm_resp_pipe).
//   tcm_resp_t      : one response slot {data, tag, error}
//   TCM_MAX_LATENCY : deepest supported response delay line
//   TCM_LFSR_SEED / TCM_LFSR_TAPS : stall generator seed and Galois mask
//   tcm_in_window() : error-window address test
//   tcm_lfsr_next() : one step of the stall LFSR
package tcm_mem_pkg;

  localparam int          TCM_MAX_LATENCY = 8;
  localparam logic [15:0] TCM_LFSR_SEED   = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] TCM_LFSR_TAPS   = 16'hB400;

  typedef struct packed {
    logic [31:0] data;
    logic [10:0] tag;
    logic        error;
  } tcm_resp_t;

  // True when addr lies in [base, base+size); size 0 disables the window.
  // The end address is formed in 33 bits so a window touching 2^32 cannot wrap.
  function automatic logic tcm_in_window(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size);
    logic [32:0] end_s;
    end_s = {1'b0, base} + {1'b0, size};
    return (size != 32'd0) && (addr >= base) && ({1'b0, addr} < end_s);
  endfunction

  function automatic logic [15:0] tcm_lfsr_next(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? TCM_LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/tcm_mem_lat_if.sv
// tcm_mem_lat_if
// Instruction (mem_i_*) and data (mem_d_*) port bundle between the core
// (master) and the simulation TCM (slave). Signal names keep the core's
// _i/_o suffixes as seen from the memory side.
interface tcm_mem_lat_if;
  logic        mem_i_rd_i;
  logic        mem_i_flush_i;
  logic        mem_i_invalidate_i;
  logic [31:0] mem_i_pc_i;
  logic        mem_i_accept_o;
  logic        mem_i_valid_o;
  logic        mem_i_error_o;
  logic [31:0] mem_i_inst_o;

  logic [31:0] mem_d_addr_i;
  logic [31:0] mem_d_data_wr_i;
  logic        mem_d_rd_i;
  logic [3:0]  mem_d_wr_i;
  logic        mem_d_cacheable_i;
  logic [10:0] mem_d_req_tag_i;
  logic        mem_d_invalidate_i;
  logic        mem_d_writeback_i;
  logic        mem_d_flush_i;
  logic [31:0] mem_d_data_rd_o;
  logic        mem_d_accept_o;
  logic        mem_d_ack_o;
  logic        mem_d_error_o;
  logic [10:0] mem_d_resp_tag_o;

  modport master (
    output mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    input  mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
    output mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
    input  mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
  );

  modport slave (
    input  mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i, mem_i_pc_i,
    output mem_i_accept_o, mem_i_valid_o, mem_i_error_o, mem_i_inst_o,
    input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i, mem_d_cacheable_i,
    input  mem_d_req_tag_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i,
    output mem_d_data_rd_o, mem_d_accept_o, mem_d_ack_o, mem_d_error_o, mem_d_resp_tag_o
  );
endinterface

// File: rtl/tcm_resp_pipe.sv
// tcm_resp_pipe
// Fixed-depth delay line for a valid flag plus a tcm_resp_t payload.
// A response entering at edge N is presented after edge N+LATENCY-1.
// Ports:
//   clk_i, rst_i (sync, active-high: empties the line)
//   in_valid / in_resp   : response captured at this edge
//   out_valid / out_resp : registered tail of the line; payload is 0 when idle
module tcm_resp_pipe
  import tcm_mem_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      in_valid,
  input  tcm_resp_t in_resp,
  output logic      out_valid,
  output tcm_resp_t out_resp
);

  localparam int DEPTH = (LATENCY > TCM_MAX_LATENCY) ? TCM_MAX_LATENCY :
                         ((LATENCY < 1) ? 1 : LATENCY);

  logic [DEPTH-1:0] valid_r;
  tcm_resp_t        resp_r [DEPTH];

  // Shift register; empty slots carry a zero payload so the tail is 0 without valid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        resp_r[i] <= '0;
      end
    end else begin
      valid_r[0] <= in_valid;
      resp_r[0]  <= in_valid ? in_resp : tcm_resp_t'('0);
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
        resp_r[i]  <= resp_r[i-1];
      end
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_resp  = resp_r[DEPTH-1];

endmodule

// File: rtl/tcm_mem_lat.sv
// tcm_mem_lat
// Simulation TCM for the riscv_core bench with configurable fetch/data
// latency, a bounded number of outstanding data requests, an error-returning
// address window and (optionally) pseudo-random accept stalls.
// Parameters: MEM_BYTES, I_LATENCY, D_LATENCY, MAX_OUTSTANDING, ERR_BASE, ERR_SIZE
// Ports:
//   clk_i : clock
//   rst_i : synchronous active-high reset (memory contents are kept)
//   bus   : tcm_mem_lat_if.slave, fetch (mem_i_*) and data (mem_d_*) ports
// Backdoor: task write(addr, byte) loads one byte with no timing.
// Build option: define TCM_MEM_STALL_EN to gate both accepts with a 16-bit LFSR.
module tcm_mem_lat
  import tcm_mem_pkg::*;
#(
  parameter int          MEM_BYTES       = 65536,
  parameter int          I_LATENCY       = 1,
  parameter int          D_LATENCY       = 1,
  parameter int          MAX_OUTSTANDING = 4,
  parameter logic [31:0] ERR_BASE        = 32'hFFFF_0000,
  parameter logic [31:0] ERR_SIZE        = 32'h0000_0000
) (
  input logic         clk_i,
  input logic         rst_i,
  tcm_mem_lat_if.slave bus
);

  localparam int AW        = $clog2(MEM_BYTES);
  localparam int MEM_WORDS = MEM_BYTES / 4;

  logic [31:0]   mem_r [MEM_WORDS];
  logic [3:0]    count_r;
  logic          d_stall_s;
  logic          i_stall_s;
  logic          d_accept_s;
  logic          i_accept_s;
  logic          d_req_s;
  logic          d_acc_s;
  logic          d_err_s;
  logic          d_wr_en_s;
  logic [AW-3:0] d_idx_s;
  logic          i_acc_s;
  logic [AW-3:0] i_idx_s;
  tcm_resp_t     d_resp_s;
  tcm_resp_t     i_resp_s;
  logic          d_ack_s;
  tcm_resp_t     d_out_s;
  logic          i_valid_s;
  tcm_resp_t     i_out_s;
  logic          unused_s;

`ifdef TCM_MEM_STALL_EN
  logic [15:0] lfsr_r;

  // Stall generator, restarts from the fixed seed on every reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_r <= TCM_LFSR_SEED;
    end else begin
      lfsr_r <= tcm_lfsr_next(lfsr_r);
    end
  end

  assign d_stall_s = (lfsr_r[1:0] == 2'b00);
  assign i_stall_s = (lfsr_r[3:2] == 2'b00);
`else
  assign d_stall_s = 1'b0;
  assign i_stall_s = 1'b0;
`endif

  // Accepts look at the registered count, so a freeing ack only reopens the port next cycle
  assign d_accept_s = !rst_i && (count_r < 4'(MAX_OUTSTANDING)) && !d_stall_s;
  assign i_accept_s = !rst_i && !i_stall_s;

  assign d_req_s   = bus.mem_d_rd_i | (|bus.mem_d_wr_i) | bus.mem_d_flush_i |
                     bus.mem_d_invalidate_i | bus.mem_d_writeback_i;
  assign d_acc_s   = d_req_s && d_accept_s;
  assign d_err_s   = tcm_in_window(bus.mem_d_addr_i, ERR_BASE, ERR_SIZE);
  assign d_wr_en_s = (|bus.mem_d_wr_i) && !d_err_s;
  assign d_idx_s   = bus.mem_d_addr_i[AW-1:2];

  assign i_acc_s = bus.mem_i_rd_i && i_accept_s;
  assign i_idx_s = bus.mem_i_pc_i[AW-1:2];

  // Data response captured at the accepting edge; the read sees the pre-write word
  always_comb begin
    d_resp_s     = '0;
    d_resp_s.tag = bus.mem_d_req_tag_i;
    if (d_err_s) begin
      d_resp_s.error = 1'b1;
    end else if (bus.mem_d_rd_i) begin
      d_resp_s.data = mem_r[d_idx_s];
    end else begin
      d_resp_s.data = 32'h0000_0000;
    end
  end

  // Fetch response: instruction word plus error-window flag, tag unused
  always_comb begin
    i_resp_s       = '0;
    i_resp_s.data  = mem_r[i_idx_s];
    i_resp_s.error = tcm_in_window(bus.mem_i_pc_i, ERR_BASE, ERR_SIZE);
  end

  // Byte-strobed store; plain always because the backdoor task also writes mem_r
  always @(posedge clk_i) begin
    if (d_acc_s && d_wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_d_wr_i[b]) begin
          mem_r[d_idx_s][8*b +: 8] <= bus.mem_d_data_wr_i[8*b +: 8];
        end
      end
    end
  end

  // Outstanding data requests: accepted but not yet acknowledged
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_r <= 4'd0;
    end else begin
      case ({d_acc_s, d_ack_s})
        2'b10:   count_r <= count_r + 4'd1;
        2'b01:   count_r <= count_r - 4'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  tcm_resp_pipe #(.LATENCY(D_LATENCY)) u_d_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (d_acc_s),
    .in_resp   (d_resp_s),
    .out_valid (d_ack_s),
    .out_resp  (d_out_s)
  );

  tcm_resp_pipe #(.LATENCY(I_LATENCY)) u_i_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (i_acc_s),
    .in_resp   (i_resp_s),
    .out_valid (i_valid_s),
    .out_resp  (i_out_s)
  );

  assign bus.mem_d_accept_o   = d_accept_s;
  assign bus.mem_d_ack_o      = d_ack_s;
  assign bus.mem_d_data_rd_o  = d_out_s.data;
  assign bus.mem_d_resp_tag_o = d_out_s.tag;
  assign bus.mem_d_error_o    = d_out_s.error;

  assign bus.mem_i_accept_o = i_accept_s;
  assign bus.mem_i_valid_o  = i_valid_s;
  assign bus.mem_i_inst_o   = i_out_s.data;
  assign bus.mem_i_error_o  = i_out_s.error;

  // Fetch flush/invalidate are accepted with no effect; cacheable is a hint only
  assign unused_s = ^{bus.mem_d_cacheable_i, bus.mem_i_flush_i,
                      bus.mem_i_invalidate_i, i_out_s.tag};

  task automatic write(input logic [31:0] addr, input logic [7:0] data);
    mem_r[addr[AW-1:2]][{addr[1:0], 3'b000} +: 8] <= data;
  endtask

endmodule

// File: tb/tb_tcm_mem_lat.sv
module tb_tcm_mem_lat;
  import tcm_mem_pkg::*;

  localparam int I_LAT   = 1;
  localparam int D_LAT   = 3;
  localparam int MAX_OUT = 2;

  typedef struct {
    logic [31:0] data;
    logic [10:0] tag;
    logic        err;
    logic        chk_data;
    int          due;
  } exp_t;

  typedef struct {
    logic        rd;
    logic [3:0]  wr;
    logic        fl;
    logic        wb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [10:0] tag;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_err;
  } dvec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t dq[$];
  exp_t iq[$];
  dvec_t dv [15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcm_mem_lat_if bus();

  tcm_mem_lat #(
    .MEM_BYTES(65536), .I_LATENCY(I_LAT), .D_LATENCY(D_LAT), .MAX_OUTSTANDING(MAX_OUT),
    .ERR_BASE(32'h0000_8000), .ERR_SIZE(32'd16)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name, input int info);
    n_chk++;
    n_fail++;
    $display("FAIL %s: info %0d (cycle %0d)", name, info, cyc);
  endtask

  // Data response scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_d_ack_o === 1'b1) begin
      if (dq.size() == 0) begin
        fail_now("d_unexpected_ack", int'(bus.mem_d_resp_tag_o));
      end else begin
        e = dq.pop_front();
        chk("d_tag", {21'd0, bus.mem_d_resp_tag_o}, {21'd0, e.tag});
        chk("d_err", {31'd0, bus.mem_d_error_o}, {31'd0, e.err});
        if (e.chk_data) chk("d_data", bus.mem_d_data_rd_o, e.data);
        chk("d_ack_cycle", cyc, e.due);
      end
    end else begin
      chk("d_idle_zero", bus.mem_d_data_rd_o | {21'd0, bus.mem_d_resp_tag_o} |
          {31'd0, bus.mem_d_error_o}, 32'd0);
    end
  end

  // Fetch response scoreboard
  always @(negedge clk) begin
    exp_t f;
    if (bus.mem_i_valid_o === 1'b1) begin
      if (iq.size() == 0) begin
        fail_now("i_unexpected_valid", int'(bus.mem_i_inst_o));
      end else begin
        f = iq.pop_front();
        chk("i_err", {31'd0, bus.mem_i_error_o}, {31'd0, f.err});
        if (f.chk_data) chk("i_inst", bus.mem_i_inst_o, f.data);
        chk("i_valid_cycle", cyc, f.due);
      end
    end else begin
      chk("i_idle_zero", bus.mem_i_inst_o | {31'd0, bus.mem_i_error_o}, 32'd0);
    end
  end

  function automatic dvec_t mkv(input logic rd, input logic [3:0] wr, input logic fl,
                                input logic wb, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [10:0] tag,
                                input logic chk_data, input logic [31:0] exp_data,
                                input logic exp_err);
    dvec_t v;
    v.rd = rd; v.wr = wr; v.fl = fl; v.wb = wb; v.addr = addr; v.wdata = wdata;
    v.tag = tag; v.chk_data = chk_data; v.exp_data = exp_data; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic d_idle();
    bus.mem_d_rd_i = 1'b0; bus.mem_d_wr_i = 4'h0; bus.mem_d_flush_i = 1'b0;
    bus.mem_d_writeback_i = 1'b0; bus.mem_d_invalidate_i = 1'b0;
    bus.mem_d_cacheable_i = 1'b0; bus.mem_d_addr_i = 32'h0;
    bus.mem_d_data_wr_i = 32'h0; bus.mem_d_req_tag_i = 11'h0;
  endtask

  task automatic i_idle();
    bus.mem_i_rd_i = 1'b0; bus.mem_i_flush_i = 1'b0;
    bus.mem_i_invalidate_i = 1'b0; bus.mem_i_pc_i = 32'h0;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] word);
    for (int b = 0; b < 4; b++) dut.write(addr + 32'(b), word[8*b +: 8]);
  endtask

  // Called at a falling edge: present the request, wait for accept, queue the expectation
  task automatic d_send(input dvec_t v);
    int n;
    exp_t e;
    bus.mem_d_rd_i = v.rd; bus.mem_d_wr_i = v.wr; bus.mem_d_flush_i = v.fl;
    bus.mem_d_writeback_i = v.wb; bus.mem_d_addr_i = v.addr;
    bus.mem_d_data_wr_i = v.wdata; bus.mem_d_req_tag_i = v.tag;
    #1;
    n = 0;
    while (bus.mem_d_accept_o !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (bus.mem_d_accept_o !== 1'b1) begin
      fail_now("d_accept_timeout", int'(v.tag));
    end else begin
      e.data = v.exp_data; e.tag = v.tag; e.err = v.exp_err;
      e.chk_data = v.chk_data; e.due = cyc + D_LAT;
      dq.push_back(e);
    end
    @(negedge clk);
    d_idle();
  endtask

  task automatic i_send(input logic [31:0] pc, input logic chk_data,
                        input logic [31:0] exp_inst, input logic exp_err);
    int n;
    exp_t e;
    bus.mem_i_rd_i = 1'b1; bus.mem_i_pc_i = pc;
    #1;
    n = 0;
    while (bus.mem_i_accept_o !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (bus.mem_i_accept_o !== 1'b1) begin
      fail_now("i_accept_timeout", int'(pc));
    end else begin
      e.data = exp_inst; e.tag = 11'h0; e.err = exp_err;
      e.chk_data = chk_data; e.due = cyc + I_LAT;
      iq.push_back(e);
    end
    @(negedge clk);
    i_idle();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((dq.size() != 0 || iq.size() != 0) && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (dq.size() != 0 || iq.size() != 0) begin
      fail_now("responses_missing", dq.size() + iq.size());
      dq.delete();
      iq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  pat;
    logic [10:0] t;
    logic        acc;
    exp_t        e;

    dv[0]  = mkv(1'b0, 4'hF, 1'b0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 11'd5,  1'b0, 32'h0,         1'b0);
    dv[1]  = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0100, 32'h0,         11'd6,  1'b1, 32'hDEAD_BEEF, 1'b0);
    dv[2]  = mkv(1'b0, 4'h2, 1'b0, 1'b0, 32'h0000_0104, 32'h0000_AB00, 11'd7,  1'b0, 32'h0,         1'b0);
    dv[3]  = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0104, 32'h0,         11'd8,  1'b1, 32'h1122_AB44, 1'b0);
    dv[4]  = mkv(1'b1, 4'hF, 1'b0, 1'b0, 32'h0000_0104, 32'h5566_7788, 11'd9,  1'b1, 32'h1122_AB44, 1'b0);
    dv[5]  = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0104, 32'h0,         11'd10, 1'b1, 32'h5566_7788, 1'b0);
    dv[6]  = mkv(1'b0, 4'hF, 1'b0, 1'b0, 32'h0000_8004, 32'h1234_5678, 11'd11, 1'b1, 32'h0,         1'b1);
    dv[7]  = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_8004, 32'h0,         11'd12, 1'b1, 32'h0,         1'b1);
    dv[8]  = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0001_8004, 32'h0,         11'd13, 1'b1, 32'hCAFE_F00D, 1'b0);
    dv[9]  = mkv(1'b0, 4'h0, 1'b1, 1'b0, 32'h0000_0100, 32'h0,         11'd14, 1'b1, 32'h0,         1'b0);
    dv[10] = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0001_0100, 32'h0,         11'h7FF, 1'b1, 32'hDEAD_BEEF, 1'b0);
    dv[11] = mkv(1'b0, 4'h0, 1'b0, 1'b1, 32'h0000_8000, 32'h0,         11'd16, 1'b1, 32'h0,         1'b1);
    dv[12] = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_8010, 32'h0,         11'd17, 1'b1, 32'h7777_7777, 1'b0);
    dv[13] = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_7FFC, 32'h0,         11'd18, 1'b1, 32'h6666_6666, 1'b0);
    dv[14] = mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_800F, 32'h0,         11'd19, 1'b1, 32'h0,         1'b1);

    rst = 1'b1;
    d_idle();
    i_idle();
    load_word(32'h0000_0000, 32'h0000_0013);
    load_word(32'h0000_0104, 32'h1122_3344);
    load_word(32'h0000_0200, 32'h0A0B_0C0D);
    load_word(32'h0000_8004, 32'hCAFE_F00D);
    load_word(32'h0000_8008, 32'h0000_0000);
    load_word(32'h0000_8010, 32'h7777_7777);
    load_word(32'h0000_7FFC, 32'h6666_6666);
    repeat (3) @(negedge clk);

    chk("rst_d_accept", {31'd0, bus.mem_d_accept_o}, 32'd0);
    chk("rst_i_accept", {31'd0, bus.mem_i_accept_o}, 32'd0);
    chk("rst_d_ack", {31'd0, bus.mem_d_ack_o}, 32'd0);
    chk("rst_i_valid", {31'd0, bus.mem_i_valid_o}, 32'd0);

    rst = 1'b0;
    #1;
    chk("release_d_accept", {31'd0, bus.mem_d_accept_o}, 32'd1);
    chk("release_i_accept", {31'd0, bus.mem_i_accept_o}, 32'd1);

    // Fetches: single, back-to-back, error window
    i_send(32'h0000_0000, 1'b1, 32'h0000_0013, 1'b0);
    wait_drain();
    i_send(32'h0000_0200, 1'b1, 32'h0A0B_0C0D, 1'b0);
    i_send(32'h0000_8008, 1'b0, 32'h0, 1'b1);
    i_send(32'h0000_7FFC, 1'b1, 32'h6666_6666, 1'b0);
    wait_drain();

    // Fetch flush / invalidate must not produce a valid
    bus.mem_i_flush_i = 1'b1;
    @(negedge clk);
    bus.mem_i_flush_i = 1'b0;
    bus.mem_i_invalidate_i = 1'b1;
    @(negedge clk);
    i_idle();
    repeat (3) @(negedge clk);

    // Data vector table, issued back-to-back
    for (int i = 0; i < 15; i++) d_send(dv[i]);
    wait_drain();

    // Backpressure with rd held high
    pat = 8'b1100_1100;
    t = 11'd40;
    bus.mem_d_rd_i = 1'b1;
    bus.mem_d_addr_i = 32'h0000_0200;
    bus.mem_d_req_tag_i = t;
    for (int i = 0; i < 8; i++) begin
      #1;
      acc = bus.mem_d_accept_o;
      chk("d_accept_backpressure", {31'd0, acc}, {31'd0, pat[7-i]});
      if (acc) begin
        e.data = 32'h0A0B_0C0D; e.tag = t; e.err = 1'b0;
        e.chk_data = 1'b1; e.due = cyc + D_LAT;
        dq.push_back(e);
      end
      @(negedge clk);
      if (acc) begin
        t = t + 11'd1;
        bus.mem_d_req_tag_i = t;
      end
    end
    d_idle();
    wait_drain();
    chk("backpressure_tags_accepted", {21'd0, t}, 32'd44);

    // Reset with reads in flight: they must never respond
    d_send(mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 11'd50, 1'b1, 32'h0A0B_0C0D, 1'b0));
    d_send(mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 11'd51, 1'b1, 32'h0A0B_0C0D, 1'b0));
    rst = 1'b1;
    dq.delete();
    #1;
    chk("rst_mid_d_accept", {31'd0, bus.mem_d_accept_o}, 32'd0);
    chk("rst_mid_i_accept", {31'd0, bus.mem_i_accept_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_d_accept", {31'd0, bus.mem_d_accept_o}, 32'd0);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    d_send(mkv(1'b1, 4'h0, 1'b0, 1'b0, 32'h0000_0200, 32'h0, 11'd52, 1'b1, 32'h0A0B_0C0D, 1'b0));
    i_send(32'h0000_0000, 1'b1, 32'h0000_0013, 1'b0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tcm_mem_lat.md
# tcm_mem_lat

Parametrised simulation TCM for the riscv_core bench. It replaces the fixed single-cycle tcm_mem. It has the same instruction and data port signals as the core's mem_i_*/mem_d_* interface, and adds configurable response latency, a bounded count of outstanding data requests, an error-returning address window and optional random stalls. A byte-wide backdoor task loads program images before reset release.

## Interface
- MEM_BYTES, 65536: memory size in bytes, power of two; AW = $clog2(MEM_BYTES)
- I_LATENCY, 1: fetch accept-to-valid cycles, 1..8
- D_LATENCY, 1: data accept-to-ack cycles, 1..8
- MAX_OUTSTANDING, 4: maximum in-flight data requests, 1..15
- ERR_BASE, 32'hFFFF_0000; ERR_SIZE, 0: byte window [ERR_BASE, ERR_BASE+ERR_SIZE) that returns error; 0 disables the window
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock domain, synchronous, active-high
- mem_i_rd_i, mem_i_flush_i, mem_i_invalidate_i  in  1  fetch request / flush / invalidate
- mem_i_pc_i  in  32  fetch address
- mem_i_accept_o, mem_i_valid_o, mem_i_error_o  out  1  fetch handshake / response
- mem_i_inst_o  out  32  fetched word
- mem_d_addr_i, mem_d_data_wr_i  in  32  data address / write data
- mem_d_rd_i  in  1; mem_d_wr_i  in  4 (byte strobes); mem_d_cacheable_i, mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i  in  1
- mem_d_req_tag_i  in  11  request tag
- mem_d_data_rd_o  out  32; mem_d_accept_o, mem_d_ack_o, mem_d_error_o  out  1
- mem_d_resp_tag_o  out  11  tag echoed with ack
- task write(addr, byte): backdoor byte write, no timing

## Operation
- Storage: 32-bit words indexed by addr[AW-1:2]. Upper address bits are ignored, so accesses wrap. Contents survive reset.
- Data request: asserted when rd, wr≠0, flush, invalidate or writeback is set. The request is accepted in any cycle where it is asserted and mem_d_accept_o=1.
- Access happens at the accepting edge:
  - Write: applies strobed bytes.
  - Read: samples the word, so it sees every write accepted in an earlier cycle.
  - rd and wr both set: the write is performed, and the returned data is the pre-write word.
  - flush/invalidate/writeback only: no memory effect; ack carries data 0.
- Error window: address inside the window gives no write, data 0, error=1.
- Response {data, tag, error} enters a D_LATENCY-deep delay line. Order is always preserved.
- Outstanding counter: +1 on accept, −1 on ack; unchanged when both happen in the same cycle. mem_d_accept_o = !rst_i && count<MAX_OUTSTANDING (before stall gating).
- Fetch: accepted when mem_i_rd_i && mem_i_accept_o. The word at pc[AW-1:2] enters an I_LATENCY delay line. mem_i_error_o=1 if pc is in the error window.
- Fetch flush/invalidate: accepted, produce no valid.
- mem_i_accept_o = !rst_i before stall gating.
- Reset mid-operation: both delay lines and the counter are cleared. In-flight requests never respond.

## Timing
- Reset values of all outputs are 0, including accept, data, tag and error.
- First accept is possible in the cycle after rst_i falls.
- Request accepted at edge N → ack/valid is high for exactly one cycle starting after edge N+LATENCY−1. With LATENCY=1, the response is visible in the cycle following acceptance.
- One request per port per cycle. Full throughput requires MAX_OUTSTANDING ≥ D_LATENCY+1; otherwise accept drops while the counter is full.
- Counter full with an ack in the current cycle: accept stays 0 this cycle, because the counter is registered.
- Response outputs are 0 whenever ack/valid is 0.

## Configuration
- TCM_MEM_STALL_EN defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset) advances every cycle.
  - mem_d_accept_o is additionally forced 0 when lfsr[1:0]==0.
  - mem_i_accept_o is forced 0 when lfsr[3:2]==0.
- Undefined: no LFSR; accepts depend only on reset and the outstanding count.

## Structure
- Package tcm_mem_pkg holds:
  - typedef tcm_resp_t {data[31:0], tag[10:0], error}
  - TCM_MAX_LATENCY = 8
  - LFSR seed and tap constants
- Sub-module tcm_resp_pipe: parametrised valid + tcm_resp_t delay line (LATENCY parameter, synchronous clear). Instantiated once for fetch and once for data.

## Test plan
- Backdoor load 32'h00000013 at 0x0, D/I_LATENCY=1; fetch pc=0 → valid one cycle later, inst=32'h00000013, error=0.
- D_LATENCY=3, MAX_OUTSTANDING=4: write 32'hDEADBEEF to 0x100 (wr=4'hF, tag 5), then read 0x100 (tag 6) on the next cycle → acks 3 cycles after each accept; tags 5 then 6; read data 32'hDEADBEEF.
- Byte write wr=4'b0010, data 32'h0000AB00 to a word holding 32'h11223344 → read returns 32'h1122AB44.
- MAX_OUTSTANDING=2, D_LATENCY=4, rd held high → accept deasserts after 2 accepts and reasserts the cycle after the first ack; no request is lost or duplicated.
- ERR_BASE=32'h8000, ERR_SIZE=16: write then read 0x8004 → both acks have error=1; read data 0; memory unchanged.
- Assert rst_i with 3 reads in flight → no ack afterwards; accept=0 during reset; a read of preloaded data after release returns the correct value.
